control_sequencer: RTL

//  Hardwired Moore controller that sequences the Datapath by issuing one control-step per clk.

---
 rtl/cpu_defs.sv | 55 +++++
 rtl/ctrl_decode.sv | 98 +++++++++
 rtl/control_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU codes,
// controller states and the control-word layout driven onto the datapath pins.
package cpu_defs;

  localparam int OPW      = 5;
  localparam int LINK_REG = 15;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_BR   = 5'b10010;
  localparam logic [OPW-1:0] OP_JR   = 5'b10011;
  localparam logic [OPW-1:0] OP_JAL  = 5'b10100;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  localparam logic [OPW-1:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU, CL_ADDI, CL_LD, CL_ST, CL_BR, CL_JR, CL_JAL, CL_NOP, CL_HALT, CL_ILL
  } op_class_t;

  typedef struct packed {
    logic pc_out, mdr_out, zlo_out, r_out, c_out, ba_out;
    logic mar_in, mdr_in, ir_in, y_in, zlow_in, pc_in, r_in, con_in;
    logic gra, grb, grc, inc_pc, read, write;
    logic [OPW-1:0] op_sel;
    logic [15:0]    r_rd;
    logic halted, illegal_op;
  } ctrl_t;

  function automatic op_class_t op_class(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return CL_ALU;
      OP_ADDI: return CL_ADDI;
      OP_LD:   return CL_LD;
      OP_ST:   return CL_ST;
      OP_BR:   return CL_BR;
      OP_JR:   return CL_JR;
      OP_JAL:  return CL_JAL;
      OP_NOP:  return CL_NOP;
      OP_HALT: return CL_HALT;
      default: return CL_ILL;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control-word decoder: maps the current step, the instruction
// opcode and the latched branch condition onto the datapath control pins.
module ctrl_decode
  import cpu_defs::*;
(
  input  state_t         state,
  input  logic [OPW-1:0] opcode,
  input  logic           con_taken,
  output ctrl_t          ctrl,
  output logic [3:0]     step
);

  op_class_t cls;
  assign cls = op_class(opcode);

  always_comb begin
    ctrl = '0;
    step = 4'd0;
    case (state)
      S_T0: begin
        step = 4'd0;
        {ctrl.pc_out, ctrl.mar_in, ctrl.inc_pc, ctrl.zlow_in} = 4'b1111;
      end
      S_T1: begin
        step = 4'd1;
        {ctrl.zlo_out, ctrl.pc_in, ctrl.read, ctrl.mdr_in} = 4'b1111;
      end
      S_T2: begin
        step = 4'd2;
        {ctrl.mdr_out, ctrl.ir_in} = 2'b11;
      end
      S_T3: begin
        step = 4'd3;
        case (cls)
          CL_ALU, CL_ADDI: {ctrl.grb, ctrl.r_out, ctrl.y_in} = 3'b111;
          CL_LD, CL_ST:    {ctrl.grb, ctrl.ba_out, ctrl.y_in} = 3'b111;
          CL_BR:           {ctrl.gra, ctrl.r_out, ctrl.con_in} = 3'b111;
          CL_JR:           {ctrl.gra, ctrl.r_out, ctrl.pc_in} = 3'b111;
          CL_JAL: begin
            // Z still holds PC+1 from fetch, so the link value needs no ALU pass
            {ctrl.zlo_out, ctrl.r_in} = 2'b11;
            ctrl.r_rd = 16'd1 << LINK_REG;
          end
          CL_ILL:          ctrl.illegal_op = 1'b1;
          default:         ;
        endcase
      end
      S_T4: begin
        step = 4'd4;
        case (cls)
          CL_ALU: begin
            {ctrl.grc, ctrl.r_out, ctrl.zlow_in} = 3'b111;
            ctrl.op_sel = opcode;
          end
          CL_ADDI, CL_LD, CL_ST: begin
            {ctrl.c_out, ctrl.zlow_in} = 2'b11;
            ctrl.op_sel = ALU_ADD;
          end
          CL_BR:   {ctrl.pc_out, ctrl.y_in} = 2'b11;
          CL_JAL:  {ctrl.gra, ctrl.r_out, ctrl.pc_in} = 3'b111;
          default: ;
        endcase
      end
      S_T5: begin
        step = 4'd5;
        case (cls)
          CL_ALU, CL_ADDI: {ctrl.zlo_out, ctrl.gra, ctrl.r_in} = 3'b111;
          CL_LD, CL_ST:    {ctrl.zlo_out, ctrl.mar_in} = 2'b11;
          CL_BR: begin
            {ctrl.c_out, ctrl.zlow_in} = 2'b11;
            ctrl.op_sel = ALU_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        step = 4'd6;
        case (cls)
          CL_LD:   {ctrl.read, ctrl.mdr_in} = 2'b11;
          CL_ST:   {ctrl.gra, ctrl.r_out, ctrl.mdr_in} = 3'b111;
          CL_BR:   if (con_taken) {ctrl.zlo_out, ctrl.pc_in} = 2'b11;
          default: ;
        endcase
      end
      S_T7: begin
        step = 4'd7;
        case (cls)
          CL_LD:   {ctrl.mdr_out, ctrl.gra, ctrl.r_in} = 3'b111;
          CL_ST:   ctrl.write = 1'b1;
          default: ;
        endcase
      end
      S_HALT:  ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore controller: holds the step register and instruction latches
// and walks fetch T0-T2 followed by the opcode-specific execute steps.
module control_sequencer
  import cpu_defs::*;
(
  input  logic           clk,
  input  logic           clr,
  input  logic           start,
  input  logic [31:0]    IR,
  input  logic           CON_out,
  output logic           PC_out,
  output logic           MDR_out,
  output logic           Zlo_out,
  output logic           R_out,
  output logic           C_out,
  output logic           BAout,
  output logic           MARin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           Zlowin,
  output logic           PCin,
  output logic           Rin,
  output logic           CONin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic [OPW-1:0] op_sel,
  output logic [15:0]    R_rd,
  output logic           halted,
  output logic           illegal_op,
  output logic [3:0]     step
);

  state_t         state;
  logic [OPW-1:0] op_q;
  logic           con_q;
  logic [OPW-1:0] cur_op;
  op_class_t      cls;
  ctrl_t          ctrl;
  logic           unused_ir;

  // IR is loaded at the end of T2, so T3 decodes it live and later steps use the latch
  assign cur_op    = (state == S_T3) ? IR[31:27] : op_q;
  assign cls       = op_class(cur_op);
  assign unused_ir = ^IR[26:0];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      op_q  <= '0;
      con_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1:   state <= S_T2;
        S_T2:   state <= S_T3;
        S_T3: begin
          op_q <= IR[31:27];
          case (cls)
            CL_JR, CL_NOP, CL_ILL: state <= S_T0;
            CL_HALT:               state <= S_HALT;
            default:               state <= S_T4;
          endcase
        end
        S_T4: state <= (cls == CL_JAL) ? S_T0 : S_T5;
        S_T5: begin
          if (cls == CL_ALU || cls == CL_ADDI) begin
            state <= S_T0;
          end else begin
            state <= S_T6;
            con_q <= CON_out;
          end
        end
        S_T6:    state <= (cls == CL_BR) ? S_T0 : S_T7;
        S_T7:    state <= S_T0;
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  ctrl_decode u_decode (
    .state     (state),
    .opcode    (cur_op),
    .con_taken (con_q),
    .ctrl      (ctrl),
    .step      (step)
  );

  assign PC_out     = ctrl.pc_out;
  assign MDR_out    = ctrl.mdr_out;
  assign Zlo_out    = ctrl.zlo_out;
  assign R_out      = ctrl.r_out;
  assign C_out      = ctrl.c_out;
  assign BAout      = ctrl.ba_out;
  assign MARin      = ctrl.mar_in;
  assign MDRin      = ctrl.mdr_in;
  assign IRin       = ctrl.ir_in;
  assign Yin        = ctrl.y_in;
  assign Zlowin     = ctrl.zlow_in;
  assign PCin       = ctrl.pc_in;
  assign Rin        = ctrl.r_in;
  assign CONin      = ctrl.con_in;
  assign Gra        = ctrl.gra;
  assign Grb        = ctrl.grb;
  assign Grc        = ctrl.grc;
  assign IncPC      = ctrl.inc_pc;
  assign Read       = ctrl.read;
  assign Write      = ctrl.write;
  assign op_sel     = ctrl.op_sel;
  assign R_rd       = ctrl.r_rd;
  assign halted     = ctrl.halted;
  assign illegal_op = ctrl.illegal_op;

endmodule
